multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the MIPS-subset datapath: shared instruction/data memory, register file, ALU, and a multi-cycle multiplier.
- Opcode/funct come from the instruction register.
- Produces per-state datapath strobes and mux selects; handles memory wait states and multiply latency.
- Traps on illegal opcodes.

Parameters:
MUL_CYCLES, 4, cycles the multiplier needs after EXEC issue (legal range 1..15)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
inst_op_i  input  6  opcode from IR; stable from DECODE until return to FETCH
funct_i  input  6  funct from IR
mem_ready_i  input  1  memory completes current access this cycle
branch_taken_i  input  1  branch condition result from ALU compare logic
pc_write_o  output  1  PC load strobe
pc_src_o  output  1  0: PC<=ALU result (PC+4); 1: PC<=ALUOut (branch target)
ir_write_o  output  1  IR load strobe
iord_o  output  1  memory address select, 0: PC, 1: ALUOut
mem_read_o  output  1  memory read request
mem_write_o  output  1  memory write request
reg_write_o  output  1  register-file write strobe
reg_dst_o  output  1  0: rt, 1: rd
mem_to_reg_o  output  1  0: ALUOut, 1: MDR
alu_src_a_o  output  1  0: PC, 1: rs
alu_src_b_o  output  2  00: rt, 01: const 4, 10: sign-ext imm, 11: imm<<2
alu_op_o  output  6  opcode passed to ALU control
state_o  output  3  current state encoding, for debug
illegal_o  output  1  sticky illegal-instruction flag

Behaviour:
- Opcode classes:
  - R-type 000000 (mult when funct=011000)
  - addi 001000, slti 001010
  - lw 100011, sw 101011
  - beq 000100, bne 000101, bge 000001, bgt 000111
  - anything else is illegal.
- States: FETCH=0, DECODE=1, EXEC=2, MULWAIT=3, MEM=4, WB=5, BRANCH=6, TRAP=7.
- Outputs are combinational from state, inst_op_i and funct_i. Any strobe not listed for a state is 0.
- While rst_i=1: state=FETCH, mul counter=0, illegal_o=0, all outputs forced 0 (state_o=0). Deassertion is sampled by the first rising edge.
- FETCH:
  - mem_read_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=001000.
  - While mem_ready_i=0: hold FETCH.
  - When mem_ready_i=1: ir_write_o=1, pc_write_o=1, pc_src_o=0; next state DECODE.
- DECODE:
  - alu_src_a_o=0, alu_src_b_o=11, alu_op_o=001000 (branch target into ALUOut).
  - Next: BRANCH for branch opcodes, TRAP for illegal opcodes, else EXEC.
- EXEC:
  - alu_src_a_o=1; alu_op_o=inst_op_i.
  - alu_src_b_o=00 for R-type, 10 otherwise.
  - Next: MEM for lw/sw.
  - For mult: load counter with MUL_CYCLES-1; next MULWAIT, or WB directly if MUL_CYCLES=1.
  - Otherwise WB.
- MULWAIT:
  - Holds EXEC's ALU selects.
  - Counter decrements each cycle; at counter=1, next is WB.
  - Total EXEC entry to WB entry = MUL_CYCLES cycles.
- MEM:
  - iord_o=1; mem_read_o=1 for lw, mem_write_o=1 for sw.
  - Requests stay asserted until mem_ready_i=1.
  - On ready: sw goes to FETCH, lw goes to WB.
- WB:
  - reg_write_o=1 for exactly one cycle.
  - reg_dst_o=1 only for R-type; mem_to_reg_o=1 only for lw.
  - Next FETCH.
- BRANCH:
  - alu_src_a_o=1, alu_src_b_o=00, alu_op_o=inst_op_i, pc_src_o=1.
  - pc_write_o=branch_taken_i.
  - Next FETCH.
- TRAP: illegal_o=1; state held until reset; no strobes asserted.
- mem_ready_i is ignored outside FETCH/MEM.
- mem_read_o and mem_write_o are never both 1.
- Reset mid-operation (e.g. during MEM or MULWAIT) immediately drops all strobes and aborts the access.
- Instruction cycle counts with zero memory wait:
  - R/addi/slti: 4
  - mult: 3+MUL_CYCLES
  - lw: 5
  - sw: 4
  - branch: 3

Test Plan:
- Reset asserted mid-MEM on sw → mem_write_o drops same cycle; after release, state_o=0, mem_read_o=1.
- add (op 000000, funct 100000), mem_ready_i always 1 → states 0,1,2,5,0; reg_write_o=1 and reg_dst_o=1 in WB only; 4 cycles.
- lw with mem_ready_i low 2 cycles in MEM → MEM held 3 cycles with mem_read_o=1 and iord_o=1; then WB with mem_to_reg_o=1, reg_dst_o=0.
- mult with MUL_CYCLES=4 → EXEC then 3 MULWAIT cycles, then WB; total 7 cycles. Repeat with MUL_CYCLES=1: EXEC goes directly to WB.
- bne with branch_taken_i=1, then beq with branch_taken_i=0 → first: BRANCH has pc_write_o=1, pc_src_o=1; second: pc_write_o=0; both 3 cycles.
- Opcode 111111 → DECODE goes to TRAP; illegal_o=1 held for 20 cycles with no strobes; cleared only by rst_i.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath: sequences fetch, decode,
// execute, multiply wait, memory access, write-back and branch; traps on illegal opcodes.
module multicycle_ctrl #(
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] inst_op_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ready_i,
    input  logic       branch_taken_i,
    output logic       pc_write_o,
    output logic       pc_src_o,
    output logic       ir_write_o,
    output logic       iord_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [5:0] alu_op_o,
    output logic [2:0] state_o,
    output logic       illegal_o
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BGE   = 6'b000001;
    localparam logic [5:0] OP_BGT   = 6'b000111;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXEC    = 3'd2,
        MULWAIT = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        BRANCH  = 3'd6,
        TRAP    = 3'd7
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [5:0] alu_op;
    } ctrl_t;

    state_t     state_q, state_d;
    logic [3:0] mul_cnt_q, mul_cnt_d;
    logic       illegal_q;
    ctrl_t      c;

    logic is_rtype, is_mult, is_lw, is_sw, is_branch, is_legal;

    always_comb begin
        is_rtype  = (inst_op_i == OP_RTYPE);
        is_mult   = is_rtype && (funct_i == FN_MULT);
        is_lw     = (inst_op_i == OP_LW);
        is_sw     = (inst_op_i == OP_SW);
        is_branch = (inst_op_i == OP_BEQ) || (inst_op_i == OP_BNE) ||
                    (inst_op_i == OP_BGE) || (inst_op_i == OP_BGT);
        is_legal  = is_rtype || is_lw || is_sw || is_branch ||
                    (inst_op_i == OP_ADDI) || (inst_op_i == OP_SLTI);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= FETCH;
            mul_cnt_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
            if (state_d == TRAP) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        c         = '0;
        case (state_q)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_op    = OP_ADDI;
                if (mem_ready_i) begin
                    c.ir_write = 1'b1;
                    c.pc_write = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                // PC + (imm<<2) lands in ALUOut so BRANCH can load it directly
                c.alu_src_b = 2'b11;
                c.alu_op    = OP_ADDI;
                if (!is_legal)      state_d = TRAP;
                else if (is_branch) state_d = BRANCH;
                else                state_d = EXEC;
            end
            EXEC, MULWAIT: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = is_rtype ? 2'b00 : 2'b10;
                c.alu_op    = inst_op_i;
                if (state_q == EXEC) begin
                    if (is_lw || is_sw) begin
                        state_d = MEM;
                    end else if (is_mult) begin
                        mul_cnt_d = MUL_LOAD;
                        state_d   = (MUL_CYCLES == 1) ? WB : MULWAIT;
                    end else begin
                        state_d = WB;
                    end
                end else begin
                    mul_cnt_d = mul_cnt_q - 4'd1;
                    if (mul_cnt_q <= 4'd1) state_d = WB;
                end
            end
            MEM: begin
                c.iord      = 1'b1;
                c.mem_read  = is_lw;
                c.mem_write = is_sw;
                if (mem_ready_i) state_d = is_lw ? WB : FETCH;
            end
            WB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = is_rtype;
                c.mem_to_reg = is_lw;
                state_d      = FETCH;
            end
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b00;
                c.alu_op    = inst_op_i;
                c.pc_src    = 1'b1;
                c.pc_write  = branch_taken_i;
                state_d     = FETCH;
            end
            default: ; // TRAP: parked until reset, no strobes
        endcase
    end

    // Reset masks everything combinationally so an in-flight access aborts immediately
    always_comb begin
        pc_write_o   = c.pc_write   & ~rst_i;
        pc_src_o     = c.pc_src     & ~rst_i;
        ir_write_o   = c.ir_write   & ~rst_i;
        iord_o       = c.iord       & ~rst_i;
        mem_read_o   = c.mem_read   & ~rst_i;
        mem_write_o  = c.mem_write  & ~rst_i;
        reg_write_o  = c.reg_write  & ~rst_i;
        reg_dst_o    = c.reg_dst    & ~rst_i;
        mem_to_reg_o = c.mem_to_reg & ~rst_i;
        alu_src_a_o  = c.alu_src_a  & ~rst_i;
        alu_src_b_o  = rst_i ? 2'b00 : c.alu_src_b;
        alu_op_o     = rst_i ? 6'b0  : c.alu_op;
        state_o      = rst_i ? 3'd0  : state_q;
        illegal_o    = illegal_q    & ~rst_i;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances (MUL_CYCLES 4 and 1) driven by directed and
// random instruction streams; expected per-cycle outputs come from an instruction-level model.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [5:0] alu_op;
        logic [2:0] state;
        logic       illegal;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst   [2];
    logic [5:0] op    [2];
    logic [5:0] funct [2];
    logic       rdy   [2];
    logic       tkn   [2];
    outs_t      act   [2];
    outs_t      exp_o [2];
    bit         chk   [2];
    int         n_err = 0;
    int         n_chk = 0;
    int         last_d = -1;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       pc_write, pc_src, ir_write, iord, mem_read, mem_write;
        logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
        logic [1:0] alu_src_b;
        logic [5:0] alu_op;
        logic [2:0] state;
        multicycle_ctrl #(.MUL_CYCLES(g == 0 ? 4 : 1)) u_dut (
            .clk_i(clk), .rst_i(rst[g]), .inst_op_i(op[g]), .funct_i(funct[g]),
            .mem_ready_i(rdy[g]), .branch_taken_i(tkn[g]),
            .pc_write_o(pc_write), .pc_src_o(pc_src), .ir_write_o(ir_write),
            .iord_o(iord), .mem_read_o(mem_read), .mem_write_o(mem_write),
            .reg_write_o(reg_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
            .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op),
            .state_o(state), .illegal_o(illegal)
        );
        assign act[g] = {pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                         reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                         alu_op, state, illegal};
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (chk[d]) begin
                n_chk++;
                if (act[d] !== exp_o[d]) begin
                    n_err++;
                    $display("FAIL dut%0d outputs @%0t: got %h want %h", d, $time, act[d], exp_o[d]);
                end
            end
        end
    end

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [5:0] o);
        return o inside {6'h00, 6'h08, 6'h0a, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h01, 6'h07};
    endfunction

    task automatic check_lit(input string name, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // One clock: drive dut d, publish its expected outputs for the negedge compare
    task automatic cyc(input int d, input logic r, input logic ready, input logic tk, input outs_t e);
        rst[d] = r; rdy[d] = ready; tkn[d] = tk;
        exp_o[d] = e; chk[d] = 1'b1; chk[1-d] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int d);
        cyc(d, 1'b1, rb(), rb(), '0);
        last_d = d;
    endtask

    task automatic use_dut(input int d);
        if (d != last_d) do_reset(d);
    endtask

    // Instruction-level model: emits the expected cycle sequence for one instruction
    task automatic run_instr(input int d, input logic [5:0] o, input logic [5:0] f,
                             input int fw, input int mw, input logic tk,
                             input bit abort_mem, output int n);
        outs_t e;
        int    m   = (d == 0) ? 4 : 1;
        bit    rt  = (o == 6'h00);
        bit    mul = rt && (f == 6'b011000);
        bit    lw  = (o == 6'h23);
        bit    sw  = (o == 6'h2b);
        bit    br  = o inside {6'h04, 6'h05, 6'h01, 6'h07};
        op[d] = o; funct[d] = f; n = 0;
        for (int i = 0; i <= fw; i++) begin
            e = '0; e.mem_read = 1; e.alu_src_b = 2'b01; e.alu_op = 6'b001000;
            if (i == fw) begin e.ir_write = 1; e.pc_write = 1; end
            cyc(d, 1'b0, i == fw, rb(), e); n++;
        end
        e = '0; e.state = 3'd1; e.alu_src_b = 2'b11; e.alu_op = 6'b001000;
        cyc(d, 1'b0, rb(), rb(), e); n++;
        if (!is_legal(o)) return;
        if (br) begin
            e = '0; e.state = 3'd6; e.alu_src_a = 1; e.alu_op = o; e.pc_src = 1; e.pc_write = tk;
            cyc(d, 1'b0, rb(), tk, e); n++;
            return;
        end
        e = '0; e.state = 3'd2; e.alu_src_a = 1; e.alu_src_b = rt ? 2'b00 : 2'b10; e.alu_op = o;
        cyc(d, 1'b0, rb(), rb(), e); n++;
        if (mul) begin
            e.state = 3'd3;
            for (int k = 1; k < m; k++) begin cyc(d, 1'b0, rb(), rb(), e); n++; end
        end
        if (lw || sw) begin
            for (int i = 0; i <= mw; i++) begin
                e = '0; e.state = 3'd4; e.iord = 1; e.mem_read = lw; e.mem_write = sw;
                if (abort_mem) begin
                    cyc(d, 1'b0, 1'b0, rb(), e); n++;
                    return;
                end
                cyc(d, 1'b0, i == mw, rb(), e); n++;
            end
            if (sw) return;
        end
        e = '0; e.state = 3'd5; e.reg_write = 1; e.reg_dst = rt; e.mem_to_reg = lw;
        cyc(d, 1'b0, rb(), rb(), e); n++;
    endtask

    task automatic run_trap(input int d, input int cycles);
        outs_t e;
        e = '0; e.state = 3'd7; e.illegal = 1;
        for (int i = 0; i < cycles; i++) cyc(d, 1'b0, rb(), rb(), e);
    endtask

    logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h08, 6'h0a, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h01, 6'h07};

    initial begin
        int n, d;
        logic [5:0] o, f;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; op[i] = '0; funct[i] = '0; rdy[i] = 1'b0; tkn[i] = 1'b0; chk[i] = 1'b0;
        end
        @(posedge clk); #1;
        do_reset(1);
        do_reset(0);

        // sw aborted by reset mid-MEM, then a normal fetch
        run_instr(0, 6'h2b, 6'h00, 0, 3, 1'b0, 1'b1, n);
        do_reset(0);
        run_instr(0, 6'h00, 6'b100000, 1, 0, 1'b0, 1'b0, n);
        check_lit("add after abort cycles", n, 5);
        run_instr(0, 6'h00, 6'b100000, 0, 0, 1'b0, 1'b0, n);
        check_lit("add cycles", n, 4);
        run_instr(0, 6'h23, 6'h00, 0, 2, 1'b0, 1'b0, n);
        check_lit("lw 2 waits cycles", n, 7);
        run_instr(0, 6'h00, 6'b011000, 0, 0, 1'b0, 1'b0, n);
        check_lit("mult M4 cycles", n, 7);
        run_instr(0, 6'h2b, 6'h00, 0, 0, 1'b0, 1'b0, n);
        check_lit("sw cycles", n, 4);
        run_instr(0, 6'h05, 6'h00, 0, 0, 1'b1, 1'b0, n);
        check_lit("bne taken cycles", n, 3);
        run_instr(0, 6'h04, 6'h00, 0, 0, 1'b0, 1'b0, n);
        check_lit("beq not taken cycles", n, 3);
        run_instr(0, 6'h3f, 6'h00, 0, 0, 1'b0, 1'b0, n);
        check_lit("illegal decode cycles", n, 2);
        run_trap(0, 20);
        do_reset(0);
        run_instr(0, 6'h08, 6'h00, 0, 0, 1'b0, 1'b0, n);
        check_lit("addi after trap cycles", n, 4);

        use_dut(1);
        run_instr(1, 6'h00, 6'b011000, 0, 0, 1'b0, 1'b0, n);
        check_lit("mult M1 cycles", n, 4);

        for (int it = 0; it < 150; it++) begin
            d = $urandom_range(0, 1);
            use_dut(d);
            if ($urandom_range(0, 15) == 0) begin
                do o = 6'($urandom); while (is_legal(o));
            end else begin
                o = ops[$urandom_range(0, 9)];
            end
            f = ($urandom_range(0, 3) == 0) ? 6'b011000 : 6'($urandom);
            run_instr(d, o, f, $urandom_range(0, 3), $urandom_range(0, 3), rb(), 1'b0, n);
            if (!is_legal(o)) begin
                run_trap(d, $urandom_range(1, 4));
                do_reset(d);
            end
        end

        chk[0] = 1'b0; chk[1] = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
